// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, redirect handling and halt freeze.
// Drives the instruction memory request and the IF/ID capture/flush strobes.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined;
// otherwise fetch_count and stall_count read as constant zero.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] pcp4,
  output logic        fetch_valid,
  output logic        fetch_flush,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  localparam logic [1:0] FETCH      = 2'd0;
  localparam logic [1:0] REDIR_WAIT = 2'd1;
  localparam logic [1:0] HALTED     = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] redir_aligned;

  // imemload is consumed by the IF/ID register directly; the fetch unit only
  // sequences it. Low redirect bits are dropped by word alignment.
  logic unused_inputs;
  assign unused_inputs = ^{imemload, redirect_pc[1:0]};

  assign redir_aligned = {redirect_pc[31:2], 2'b00};

  // Address outputs come straight from the PC register; pcp4 wraps naturally.
  assign imemaddr = pc_q;
  assign pcp4     = pc_q + 32'd4;

  // Output strobes decoded from state and this cycle's inputs.
  always_comb begin
    imemREN     = 1'b0;
    fetch_valid = 1'b0;
    fetch_flush = 1'b0;
    unique case (state_q)
      FETCH: begin
        imemREN     = 1'b1;
        fetch_flush = halt | redirect_en;
        fetch_valid = ihit & ~stall & ~redirect_en & ~halt;
      end
      REDIR_WAIT: begin
        // Nothing valid is in flight; a fresh redirect still squashes IF/ID.
        imemREN     = 1'b1;
        fetch_flush = halt | redirect_en;
      end
      default: begin
        imemREN     = 1'b0;
      end
    endcase
  end

  // Next-state, next-PC and redirect-target selection.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    if (state_q == HALTED) begin
      state_d = HALTED;
    end else if (halt) begin
      // Halt beats both redirect and hit; PC freezes where it is.
      state_d = HALTED;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (redirect_en) begin
            if (ihit) begin
              pc_d = redir_aligned;
            end else begin
              target_d = redir_aligned;
              state_d  = REDIR_WAIT;
            end
          end else if (ihit && !stall) begin
            pc_d = pc_q + 32'd4;
          end
        end
        REDIR_WAIT: begin
          // Wait for the outstanding read to drain before moving the address.
          if (ihit) begin
            pc_d    = redirect_en ? redir_aligned : target_q;
            state_d = FETCH;
          end else if (redirect_en) begin
            target_d = redir_aligned;
          end
        end
        default: begin
          state_d = HALTED;
        end
      endcase
    end
  end

  // State, PC and latched redirect target; reset drops any pending redirect.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      target_q <= 32'h00000000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_count_q;

  // Performance counters: delivered instructions and stalled fetch cycles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_count_q <= 32'h00000000;
      stall_count_q <= 32'h00000000;
    end else begin
      if (fetch_valid) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if ((state_q == FETCH) && stall) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`else
  assign fetch_count = 32'h00000000;
  assign stall_count = 32'h00000000;
`endif

  // Capture and clear of IF/ID must never be requested together.
  assert property (@(posedge CLK) disable iff (!nRST) !(fetch_valid && fetch_flush));

  // HALTED is only left through reset.
  assert property (@(posedge CLK) disable iff (!nRST) (state_q == HALTED) |=> (state_q == HALTED));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default RESET_PC = 0).
module tb_fetch_unit;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] pcp4;
  logic        fetch_valid;
  logic        fetch_flush;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  int unsigned n_total;
  int unsigned n_pass;

  fetch_unit dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .imemload    (imemload),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .pcp4        (pcp4),
    .fetch_valid (fetch_valid),
    .fetch_flush (fetch_flush),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change 1ns after the rising edge; outputs are checked 1ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit        = 1'b0;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    halt        = 1'b0;
    imemload    = 32'hDEADBEEF;
  endtask

  task automatic do_reset();
    idle_inputs();
    tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  // Move PC with a redirect that hits in FETCH; checks the flush strobe.
  task automatic set_pc(input logic [31:0] addr);
    redirect_en = 1'b1;
    redirect_pc = addr;
    ihit        = 1'b1;
    #1;
    n_total++;
    if (fetch_flush !== 1'b1 || fetch_valid !== 1'b0)
      $display("FAIL set_pc_strobes: flush=%b valid=%b required flush=1 valid=0",
               fetch_flush, fetch_valid);
    else n_pass++;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    #2;
    n_total++;
    if (imemaddr !== 32'h0 || imemREN !== 1'b1)
      $display("FAIL reset_addr: addr=%h ren=%b required addr=00000000 ren=1", imemaddr, imemREN);
    else n_pass++;
    n_total++;
    if (fetch_valid !== 1'b0 || fetch_flush !== 1'b0)
      $display("FAIL reset_strobes: valid=%b flush=%b required 0 0", fetch_valid, fetch_flush);
    else n_pass++;
    n_total++;
    if (fetch_count !== 32'h0 || stall_count !== 32'h0)
      $display("FAIL reset_counters: fetch=%0d stall=%0d required 0 0", fetch_count, stall_count);
    else n_pass++;
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h0;
    exp_addr[1] = 32'h4;
    exp_addr[2] = 32'h8;
    ihit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (imemaddr !== exp_addr[i] || imemREN !== 1'b1)
        $display("FAIL seq_addr[%0d]: addr=%h ren=%b required addr=%h ren=1",
                 i, imemaddr, imemREN, exp_addr[i]);
      else n_pass++;
      n_total++;
      if (pcp4 !== exp_addr[i] + 32'd4)
        $display("FAIL seq_pcp4[%0d]: got %h required %h", i, pcp4, exp_addr[i] + 32'd4);
      else n_pass++;
      n_total++;
      if (fetch_valid !== 1'b1 || fetch_flush !== 1'b0)
        $display("FAIL seq_valid[%0d]: valid=%b flush=%b required 1 0", i, fetch_valid, fetch_flush);
      else n_pass++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    logic exp_valid [3];
    exp_valid[0] = 1'b0;
    exp_valid[1] = 1'b0;
    exp_valid[2] = 1'b1;
    set_pc(32'h10);
    ihit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stall = (i < 2);
      #1;
      n_total++;
      if (imemaddr !== 32'h10 || fetch_valid !== exp_valid[i])
        $display("FAIL stall[%0d]: addr=%h valid=%b required addr=00000010 valid=%b",
                 i, imemaddr, fetch_valid, exp_valid[i]);
      else n_pass++;
      tick();
    end
    idle_inputs();
    #1;
    n_total++;
    if (imemaddr !== 32'h14)
      $display("FAIL stall_advance: addr=%h required 00000014", imemaddr);
    else n_pass++;
  endtask

  task automatic test_redirect_wait();
    set_pc(32'h20);
    redirect_en = 1'b1;
    redirect_pc = 32'h103;
    #1;
    n_total++;
    if (fetch_flush !== 1'b1 || fetch_valid !== 1'b0)
      $display("FAIL redir_flush: flush=%b valid=%b required 1 0", fetch_flush, fetch_valid);
    else n_pass++;
    tick();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_total++;
      if (imemaddr !== 32'h20 || imemREN !== 1'b1 || fetch_valid !== 1'b0)
        $display("FAIL redir_hold[%0d]: addr=%h ren=%b valid=%b required 00000020 1 0",
                 i, imemaddr, imemREN, fetch_valid);
      else n_pass++;
      tick();
    end
    ihit = 1'b1;
    #1;
    n_total++;
    if (fetch_valid !== 1'b0 || imemaddr !== 32'h20)
      $display("FAIL redir_hit_discard: valid=%b addr=%h required 0 00000020",
               fetch_valid, imemaddr);
    else n_pass++;
    tick();
    idle_inputs();
    #1;
    n_total++;
    if (imemaddr !== 32'h100)
      $display("FAIL redir_target: addr=%h required 00000100", imemaddr);
    else n_pass++;
    // A second redirect while waiting replaces the latched target.
    redirect_en = 1'b1;
    redirect_pc = 32'h180;
    tick();
    redirect_pc = 32'h20B;
    tick();
    idle_inputs();
    ihit = 1'b1;
    tick();
    idle_inputs();
    #1;
    n_total++;
    if (imemaddr !== 32'h208)
      $display("FAIL redir_overwrite: addr=%h required 00000208", imemaddr);
    else n_pass++;
  endtask

  task automatic test_wrap();
    set_pc(32'hFFFFFFFC);
    ihit = 1'b1;
    #1;
    n_total++;
    if (pcp4 !== 32'h0 || fetch_valid !== 1'b1)
      $display("FAIL wrap_pcp4: pcp4=%h valid=%b required 00000000 1", pcp4, fetch_valid);
    else n_pass++;
    tick();
    idle_inputs();
    #1;
    n_total++;
    if (imemaddr !== 32'h0)
      $display("FAIL wrap_addr: addr=%h required 00000000", imemaddr);
    else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    set_pc(32'h60);
    redirect_en = 1'b1;
    redirect_pc = 32'h300;
    tick();
    idle_inputs();
    nRST = 1'b0;
    #1;
    n_total++;
    if (imemaddr !== 32'h0)
      $display("FAIL wait_reset_addr: addr=%h required 00000000", imemaddr);
    else n_pass++;
    tick();
    nRST = 1'b1;
    ihit = 1'b1;
    #1;
    n_total++;
    if (fetch_valid !== 1'b1)
      $display("FAIL wait_reset_state: valid=%b required 1", fetch_valid);
    else n_pass++;
    tick();
    idle_inputs();
    #1;
    n_total++;
    if (imemaddr !== 32'h4)
      $display("FAIL wait_reset_drop: addr=%h required 00000004", imemaddr);
    else n_pass++;
  endtask

  task automatic test_halt();
    set_pc(32'h40);
    halt        = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'h80;
    ihit        = 1'b1;
    #1;
    n_total++;
    if (fetch_flush !== 1'b1 || fetch_valid !== 1'b0)
      $display("FAIL halt_flush: flush=%b valid=%b required 1 0", fetch_flush, fetch_valid);
    else n_pass++;
    tick();
    halt        = 1'b0;
    redirect_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_total++;
      if (imemREN !== 1'b0 || imemaddr !== 32'h40 || fetch_valid !== 1'b0 || fetch_flush !== 1'b0)
        $display("FAIL halted[%0d]: ren=%b addr=%h valid=%b flush=%b required 0 00000040 0 0",
                 i, imemREN, imemaddr, fetch_valid, fetch_flush);
      else n_pass++;
      redirect_en = (i == 4);
      redirect_pc = 32'h80;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_perf_counters();
    logic [31:0] exp_fetch;
    logic [31:0] exp_stall;
`ifdef FETCH_PERF_CNT_EN
    exp_fetch = 32'd5;
    exp_stall = 32'd2;
`else
    exp_fetch = 32'd0;
    exp_stall = 32'd0;
`endif
    do_reset();
    ihit = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    idle_inputs();
    tick();
    n_total++;
    if (fetch_count !== exp_fetch)
      $display("FAIL perf_fetch_count: got %0d required %0d", fetch_count, exp_fetch);
    else n_pass++;
    n_total++;
    if (stall_count !== exp_stall)
      $display("FAIL perf_stall_count: got %0d required %0d", stall_count, exp_stall);
    else n_pass++;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    nRST    = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_wrap();
    test_reset_in_wait();
    test_halt();
    test_perf_counters();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have port CLK, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-003 SHALL have port nRST, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port ihit, input, 1, meaning instruction memory has returned data for imemaddr this cycle.
REQ-005 SHALL have port imemload, input, 32, meaning the instruction word returned with ihit (passed through to the IF/ID register).
REQ-006 SHALL have port stall, input, 1, meaning the hazard unit is freezing fetch.
REQ-007 SHALL have port redirect_en, input, 1, meaning a branch or jump resolved downstream to redirect_pc.
REQ-008 SHALL have port redirect_pc, input, 32, meaning the redirect target.
REQ-009 SHALL have port halt, input, 1, meaning a HALT has been committed downstream.
REQ-010 SHALL have port imemREN, output, 1, meaning the instruction read request.
REQ-011 SHALL have port imemaddr, output, 32, meaning the fetch address.
REQ-012 SHALL have port pcp4, output, 32, meaning imemaddr+4 for the IF/ID register.
REQ-013 SHALL have port fetch_valid, output, 1, meaning the IF/ID register shall capture imemload/pcp4 this cycle.
REQ-014 SHALL have port fetch_flush, output, 1, meaning the IF/ID register shall clear to zero this cycle.
REQ-015 SHALL have ports fetch_count and stall_count, outputs, 32 each, meaning performance counters (see Configuration).

Function
REQ-016 SHALL implement states FETCH, REDIR_WAIT and HALTED, with pc and redirect target held in registers.
REQ-017 SHALL drive imemaddr=pc and pcp4=pc+4 (modulo 2^32, wrapping 32'hFFFFFFFC to 32'h00000000) combinationally from the pc register.
REQ-018 In FETCH, SHALL drive imemREN=1.
REQ-019 In FETCH with ihit=1, stall=0, redirect_en=0, halt=0, SHALL assert fetch_valid and set pc<=pc+4 at the next edge.
REQ-020 In FETCH with ihit=1 and stall=1, SHALL deassert fetch_valid and hold pc, so the instruction is refetched.
REQ-021 In FETCH with redirect_en=1 and ihit=1, SHALL assert fetch_flush, deassert fetch_valid, discard the hit and set pc<={redirect_pc[31:2],2'b00}, regardless of stall.
REQ-022 In FETCH with redirect_en=1 and ihit=0, SHALL assert fetch_flush, latch {redirect_pc[31:2],2'b00} as the target, hold pc and enter REDIR_WAIT.
REQ-023 In REDIR_WAIT, SHALL keep imemREN=1 and imemaddr unchanged, never assert fetch_valid, and overwrite the latched target if redirect_en is asserted again.
REQ-024 In REDIR_WAIT on ihit=1, SHALL discard the data, load pc from the latched target (or from redirect_pc if redirect_en is asserted that cycle) and return to FETCH.
REQ-025 On halt=1 in any state, SHALL enter HALTED at the next edge, freeze pc, and assert fetch_flush that cycle; halt SHALL take priority over redirect_en and ihit.
REQ-026 In HALTED, SHALL drive imemREN=0, fetch_valid=0 and fetch_flush=0; HALTED SHALL be left only by reset.
REQ-027 SHALL assert fetch_valid and fetch_flush mutually exclusively.

Reset
REQ-028 On nRST=0, SHALL immediately set pc=RESET_PC, state=FETCH, latched target=0 and counters=0.
REQ-029 On reset during REDIR_WAIT, SHALL drop the pending redirect.
REQ-030 On the first edge after reset release, SHALL present imemaddr=RESET_PC with imemREN=1.

Configuration
REQ-031 With macro FETCH_PERF_CNT_EN defined, SHALL increment fetch_count on each fetch_valid cycle and stall_count on each FETCH cycle with stall=1, both wrapping at 2^32.
REQ-032 Without FETCH_PERF_CNT_EN defined, SHALL tie fetch_count and stall_count to 0 and instantiate no counter registers.

Verification
REQ-033 Verification SHALL cover: reset with RESET_PC=0 and ihit=1 every cycle for 3 cycles -> imemaddr 0,4,8; fetch_valid=1 each cycle; pcp4 4,8,12.
REQ-034 Verification SHALL cover: pc=0x10, ihit=1, stall=1 for 2 cycles, then stall=0 -> imemaddr stays 0x10, fetch_valid 0,0,1, then imemaddr=0x14.
REQ-035 Verification SHALL cover: pc=0x20, ihit=0, redirect_en=1, redirect_pc=0x103 -> fetch_flush=1, REDIR_WAIT, imemaddr holds 0x20 until ihit, then imemaddr=0x100, fetch_valid=0 on that hit.
REQ-036 Verification SHALL cover: pc=0x40, halt=1 together with redirect_en=1 and redirect_pc=0x80 -> HALTED, imemREN=0, imemaddr stays 0x40 for 10 cycles.
REQ-037 Verification SHALL cover: pc=0xFFFFFFFC, ihit=1 -> pcp4=0, next imemaddr=0.
REQ-038 Verification SHALL cover: with FETCH_PERF_CNT_EN, 5 valid fetches and 2 stall cycles -> fetch_count=5, stall_count=2; without the macro, both read 0.
